// File: rtl/gpp_mailbox_pkg.sv
// Register map, bit positions and STATUS layout for the GPP mailbox.
// Shared by the top level and the bench-facing documentation of the map.
package gpp_mailbox_pkg;

  localparam logic [11:0] ADDR_TXDATA = 12'h000;
  localparam logic [11:0] ADDR_RXDATA = 12'h004;
  localparam logic [11:0] ADDR_STATUS = 12'h008;
  localparam logic [11:0] ADDR_CTRL   = 12'h00C;

  localparam int STATUS_TX_FULL  = 0;
  localparam int STATUS_TX_EMPTY = 1;
  localparam int STATUS_RX_FULL  = 2;
  localparam int STATUS_RX_EMPTY = 3;

  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;
  localparam int CTRL_IRQ_EN   = 2;

  typedef struct packed {
    logic [11:0] rsvd_hi;
    logic [3:0]  rx_count;
    logic [3:0]  rsvd_mid;
    logic [3:0]  tx_count;
    logic [3:0]  rsvd_lo;
    logic        rx_empty;
    logic        rx_full;
    logic        tx_empty;
    logic        tx_full;
  } status_t;

endpackage

// File: rtl/gpp_mbx_fifo.sv
// Synchronous FIFO with push/pop/flush; flush wins over both. Head is combinational,
// zero when empty. Push while full and pop while empty are ignored.
module gpp_mbx_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            din_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [DW-1:0]            dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Flags come from pre-edge state, so a full FIFO rejects a push even if it pops now.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/gpp_mailbox.sv
// APB3 mailbox on the GPP port: TX/RX word FIFOs bridged to valid/ready streams.
// Zero-wait-state APB, side effects at the closing edge; irq is registered.
module gpp_mailbox
  import gpp_mailbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [11:0]   PADDR,
  input  logic [31:0]   PWDATA,
  input  logic          PWRITE,
  input  logic          PSEL,
  input  logic          PENABLE,
  output logic [31:0]   PRDATA,
  output logic          PREADY,
  output logic          PSLVERR,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          access;
  logic [11:0]   addr_w;
  logic          unused_paddr;
  logic          tx_push, tx_flush, tx_full, tx_empty;
  logic          rx_pop, rx_flush, rx_full, rx_empty;
  logic [DW-1:0] rx_head;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          ctrl_wr;
  logic          irq_en_q, irq_en_d, irq_q, irq_d;
  status_t       status;
  logic [31:0]   ctrl_rd;

  assign access       = PSEL & PENABLE;
  assign addr_w       = {PADDR[11:2], 2'b00};
  assign unused_paddr = ^PADDR[1:0];
  assign PREADY       = 1'b1;

  assign tx_push  = access & PWRITE & (addr_w == ADDR_TXDATA) & ~tx_full;
  assign rx_pop   = access & ~PWRITE & (addr_w == ADDR_RXDATA) & ~rx_empty;
  assign ctrl_wr  = access & PWRITE & (addr_w == ADDR_CTRL);
  assign tx_flush = ctrl_wr & PWDATA[CTRL_TX_FLUSH];
  assign rx_flush = ctrl_wr & PWDATA[CTRL_RX_FLUSH];

  gpp_mbx_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
    .clk(HCLK), .rst_n(HRESETn),
    .push_i(tx_push), .din_i(PWDATA[DW-1:0]),
    .pop_i(tx_valid & tx_ready), .flush_i(tx_flush),
    .dout_o(tx_data), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
  );

  gpp_mbx_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
    .clk(HCLK), .rst_n(HRESETn),
    .push_i(rx_valid & rx_ready), .din_i(rx_data),
    .pop_i(rx_pop), .flush_i(rx_flush),
    .dout_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
  );

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  always_comb begin
    status          = '0;
    status.tx_full  = tx_full;
    status.tx_empty = tx_empty;
    status.rx_full  = rx_full;
    status.rx_empty = rx_empty;
    status.tx_count = 4'(tx_cnt);
    status.rx_count = 4'(rx_cnt);
    ctrl_rd              = '0;
    ctrl_rd[CTRL_IRQ_EN] = irq_en_q;
  end

  // Read data and error are purely combinational and zero outside the access phase.
  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (access) begin
      case (addr_w)
        ADDR_TXDATA: PSLVERR = ~PWRITE | tx_full;
        ADDR_RXDATA: begin
          PSLVERR = PWRITE | rx_empty;
          if (!PWRITE) PRDATA = 32'(rx_head);
        end
        ADDR_STATUS: begin
          PSLVERR = PWRITE;
          if (!PWRITE) PRDATA = status;
        end
        ADDR_CTRL:   if (!PWRITE) PRDATA = ctrl_rd;
        default:     PSLVERR = 1'b1;
      endcase
    end
  end

  assign irq_en_d = ctrl_wr ? PWDATA[CTRL_IRQ_EN] : irq_en_q;
  assign irq_d    = irq_en_q & ~rx_empty;
  assign irq      = irq_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_gpp_mailbox.sv
// Self-checking bench for gpp_mailbox: register decode table, TX/RX scoreboards,
// and hand-written sequences for simultaneous push/pop, flush and async reset.
module tb_gpp_mailbox;

  logic        HCLK, HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  gpp_mailbox #(.DEPTH(8), .DW(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .irq(irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // TX scoreboard: every word handed downstream must be the oldest accepted write.
  always @(negedge HCLK) begin
    if (HRESETn && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_extra: got 0x%08h expected no word", tx_data);
      end else begin
        check("tx_order", tx_data, tx_q.pop_front());
      end
    end
  end

  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     input logic pop, output logic [31:0] rd, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    if (pop) tx_ready = 1'b1;
    @(negedge HCLK);
    rd = PRDATA; err = PSLVERR;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    if (pop) tx_ready = 1'b0;
  endtask

  task automatic apb_rd(input string name, input logic [11:0] a,
                        input logic [31:0] exp, input logic exp_err);
    logic [31:0] rd; logic err;
    apb(1'b0, a, 32'h0, 1'b0, rd, err);
    check({name, "_rdata"}, rd, exp);
    check({name, "_err"}, err, exp_err);
  endtask

  task automatic apb_wr(input string name, input logic [11:0] a,
                        input logic [31:0] d, input logic exp_err);
    logic [31:0] rd; logic err;
    apb(1'b1, a, d, 1'b0, rd, err);
    check({name, "_err"}, err, exp_err);
  endtask

  task automatic tx_write(input logic [31:0] w);
    tx_q.push_back(w);
    apb_wr("tx_write", 12'h000, w, 1'b0);
  endtask

  task automatic rx_send(input logic [31:0] w);
    rx_data = w; rx_valid = 1'b1;
    @(negedge HCLK);
    check("rx_ready", rx_ready, 1'b1);
    @(posedge HCLK); #1;
    rx_valid = 1'b0;
    rx_q.push_back(w);
  endtask

  task automatic drain_tx(input string name);
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && tx_q.size() != 0; i++) @(posedge HCLK);
    #1;
    tx_ready = 1'b0;
    check({name, "_left"}, tx_q.size(), 0);
    check({name, "_valid"}, tx_valid, 1'b0);
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        err;

    vecs[0]  = '{1'b0, 12'h008, 32'h0, 32'h0000_000A, 1'b0};
    vecs[1]  = '{1'b0, 12'h00B, 32'h0, 32'h0000_000A, 1'b0};
    vecs[2]  = '{1'b0, 12'h000, 32'h0, 32'h0,         1'b1};
    vecs[3]  = '{1'b1, 12'h004, 32'h5, 32'h0,         1'b1};
    vecs[4]  = '{1'b1, 12'h008, 32'hF, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 12'h010, 32'h0, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 12'h3FC, 32'h4, 32'h0,         1'b1};
    vecs[7]  = '{1'b0, 12'h004, 32'h0, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 12'h00C, 32'h4, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 12'h00C, 32'h0, 32'h0000_0004, 1'b0};
    vecs[10] = '{1'b1, 12'h00C, 32'h3, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 12'h00C, 32'h0, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 12'h008, 32'h0, 32'h0000_000A, 1'b0};

    HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0;
    PENABLE = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    #3;
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pready", PREADY, 1'b1);
    check("rst_pslverr", PSLVERR, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 32'h0);
    check("rst_rx_ready", rx_ready, 1'b1);
    check("rst_irq", irq, 1'b0);
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Register decode and error table.
    for (int i = 0; i < 13; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, err);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
    end

    // Setup phase alone must not drive read data or error.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h008;
    @(negedge HCLK);
    check("setup_prdata", PRDATA, 32'h0);
    PADDR = 12'h020;
    #1;
    check("setup_pslverr", PSLVERR, 1'b0);
    @(posedge HCLK); #1;
    PSEL = 1'b0;

    // Fill TX, overflow write, drain in order.
    tx_write(32'hA5A5_0001);
    check("tx_valid_after_write", tx_valid, 1'b1);
    for (int i = 2; i <= 8; i++) tx_write(32'hA5A5_0000 + 32'(i));
    apb_rd("status_tx_full", 12'h008, 32'h0000_0809, 1'b0);
    apb_wr("tx_overflow", 12'h000, 32'hDEAD_BEEF, 1'b1);
    drain_tx("tx_drain8");

    // RX traffic raises irq; reads pop in order; empty read errors; irq falls.
    apb_wr("ctrl_irq_en", 12'h00C, 32'h4, 1'b0);
    rx_send(32'h1111_1111);
    rx_send(32'h2222_2222);
    check("irq_rise", irq, 1'b1);
    apb_rd("rx_read1", 12'h004, rx_q.pop_front(), 1'b0);
    apb_rd("rx_read2", 12'h004, rx_q.pop_front(), 1'b0);
    apb_rd("rx_read_empty", 12'h004, 32'h0, 1'b1);
    check("irq_fall", irq, 1'b0);

    // TX write coinciding with a stream pop keeps the count.
    tx_write(32'hC0DE_0001);
    tx_write(32'hC0DE_0002);
    tx_write(32'hC0DE_0003);
    tx_q.push_back(32'hC0DE_0004);
    apb(1'b1, 12'h000, 32'hC0DE_0004, 1'b1, rd, err);
    check("push_pop_err", err, 1'b0);
    apb_rd("status_push_pop", 12'h008, 32'h0000_0308, 1'b0);
    for (int i = 5; i <= 9; i++) tx_write(32'hC0DE_0000 + 32'(i));
    apb(1'b1, 12'h000, 32'hBAD0_BAD0, 1'b1, rd, err);
    check("full_pop_write_err", err, 1'b1);
    apb_rd("status_full_pop", 12'h008, 32'h0000_0708, 1'b0);
    drain_tx("tx_drain_mixed");

    // RX flush with a word arriving on the same edge.
    for (int i = 1; i <= 5; i++) rx_send(32'h3333_0000 + 32'(i));
    apb_rd("status_rx5", 12'h008, 32'h0005_0002, 1'b0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h00C; PWDATA = 32'h2;
    @(posedge HCLK); #1;
    PENABLE = 1'b1; rx_data = 32'h9999_9999; rx_valid = 1'b1;
    @(negedge HCLK);
    check("rx_flush_err", PSLVERR, 1'b0);
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; rx_valid = 1'b0;
    rx_q.delete();
    apb_rd("status_rx_flushed", 12'h008, 32'h0000_000A, 1'b0);
    apb_rd("ctrl_selfclear", 12'h00C, 32'h0, 1'b0);
    check("irq_after_flush", irq, 1'b0);
    apb_rd("rx_read_after_flush", 12'h004, 32'h0, 1'b1);

    // Asynchronous reset with both FIFOs occupied and irq asserted.
    apb_wr("ctrl_irq_en2", 12'h00C, 32'h4, 1'b0);
    tx_write(32'h7777_0001);
    tx_write(32'h7777_0002);
    rx_send(32'h8888_0001);
    apb_rd("status_pre_reset", 12'h008, 32'h0001_0200, 1'b0);
    check("irq_pre_reset", irq, 1'b1);
    #2;
    HRESETn = 1'b0;
    #1;
    check("arst_tx_valid", tx_valid, 1'b0);
    check("arst_tx_data", tx_data, 32'h0);
    check("arst_rx_ready", rx_ready, 1'b1);
    check("arst_irq", irq, 1'b0);
    check("arst_prdata", PRDATA, 32'h0);
    check("arst_pslverr", PSLVERR, 1'b0);
    tx_q.delete();
    rx_q.delete();
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESETn = 1'b1;
    apb_rd("status_post_reset", 12'h008, 32'h0000_000A, 1'b0);
    apb_rd("ctrl_post_reset", 12'h00C, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
